// File: rtl/ahb_subordinate_responder.sv
// AHB subordinate with a decoded byte-addressable register window, programmable
// wait states and the two-cycle ERROR response for out-of-window, oversized or misaligned beats.
module ahb_subordinate_responder #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'h0000_0000,
    parameter int                    MEM_ADDR_BITS = 8,
    parameter int                    WAIT_STATES   = 0
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    hselx,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [3:0]              hprot,
    input  logic [DATA_WIDTH/8-1:0] hwstrb,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic                    hready,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [DATA_WIDTH-1:0]   hrdata,
    output logic                    hexokay
);

    localparam int         STRB_W     = DATA_WIDTH / 8;
    localparam int         WORD_SHIFT = $clog2(STRB_W);
    localparam int         IDX_W      = MEM_ADDR_BITS - WORD_SHIFT;
    localparam int         DEPTH      = 2 ** IDX_W;
    localparam logic [2:0] SIZE_MAX   = 3'($clog2(STRB_W));
    localparam logic [3:0] WAIT_LOAD  = (WAIT_STATES > 32'sd0) ? 4'(WAIT_STATES - 32'sd1) : 4'd0;
    localparam bit         ZERO_WAIT  = (WAIT_STATES == 32'sd0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERR1   = 2'd2,
        ST_ERR2   = 2'd3
    } state_t;

    state_t                   state_r;
    logic [3:0]               wait_cnt_r;
    logic                     hreadyout_r;
    logic                     hresp_r;
    logic                     dp_valid_r;
    logic                     dp_write_r;
    logic [MEM_ADDR_BITS-1:0] dp_addr_r;
    logic [2:0]               dp_size_r;
    logic [DATA_WIDTH-1:0]    mem_r [DEPTH];

    logic                     accept_s;
    logic                     err_s;
    logic                     complete_wr_s;
    logic [IDX_W-1:0]         word_idx_s;
    logic [STRB_W-1:0]        wr_mask_s;
    logic                     unused_s;

    function automatic logic misaligned_f(input logic [2:0] addr_lo, input logic [2:0] size);
        logic bad;
        case (size)
            3'd0:    bad = 1'b0;
            3'd1:    bad = addr_lo[0];
            3'd2:    bad = |addr_lo[1:0];
            3'd3:    bad = |addr_lo[2:0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [STRB_W-1:0] lane_mask_f(input logic [2:0] offset, input logic [2:0] size);
        logic [3:0]        nbytes;
        logic [STRB_W-1:0] mask;
        nbytes = 4'd1 << size;
        mask   = '0;
        for (int i = 0; i < STRB_W; i++) begin
            mask[i] = (4'(i) >= {1'b0, offset}) && (4'(i) < ({1'b0, offset} + nbytes));
        end
        return mask;
    endfunction

    assign accept_s = hselx && hready && htrans[1];
    assign err_s    = (haddr[ADDR_WIDTH-1:MEM_ADDR_BITS] != BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_BITS])
                   || (hsize > SIZE_MAX)
                   || misaligned_f(haddr[2:0], hsize);

    // A pending write lands on the edge that ends its data phase, which is always an IDLE-state cycle.
    assign complete_wr_s = (state_r == ST_IDLE) && dp_valid_r && dp_write_r && hreadyout_r;
    assign word_idx_s    = dp_addr_r[MEM_ADDR_BITS-1:WORD_SHIFT];
    assign wr_mask_s     = hwstrb & lane_mask_f(3'(dp_addr_r[WORD_SHIFT-1:0]), dp_size_r);

    assign hreadyout = hreadyout_r;
    assign hresp     = hresp_r;
    assign hexokay   = 1'b0;
    assign hrdata    = (dp_valid_r && !dp_write_r) ? mem_r[word_idx_s] : '0;
    assign unused_s  = ^{hburst, hprot, htrans[0]};

    // Transfer FSM: address-phase capture, wait-state countdown and the two-cycle error response.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 4'd0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
            dp_valid_r  <= 1'b0;
            dp_write_r  <= 1'b0;
            dp_addr_r   <= '0;
            dp_size_r   <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_ERR2: begin
                    if (accept_s) begin
                        dp_addr_r  <= haddr[MEM_ADDR_BITS-1:0];
                        dp_write_r <= hwrite;
                        dp_size_r  <= hsize;
                        if (err_s) begin
                            state_r     <= ST_ERR1;
                            hreadyout_r <= 1'b0;
                            hresp_r     <= 1'b1;
                            dp_valid_r  <= 1'b0;
                        end else if (ZERO_WAIT) begin
                            state_r     <= ST_IDLE;
                            hreadyout_r <= 1'b1;
                            hresp_r     <= 1'b0;
                            dp_valid_r  <= 1'b1;
                        end else begin
                            state_r     <= ST_ACCESS;
                            wait_cnt_r  <= WAIT_LOAD;
                            hreadyout_r <= 1'b0;
                            hresp_r     <= 1'b0;
                            dp_valid_r  <= 1'b1;
                        end
                    end else begin
                        state_r     <= ST_IDLE;
                        hreadyout_r <= 1'b1;
                        hresp_r     <= 1'b0;
                        dp_valid_r  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt_r != 4'd0) begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end else begin
                        state_r     <= ST_IDLE;
                        hreadyout_r <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state_r     <= ST_ERR2;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    wait_cnt_r  <= 4'd0;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= 1'b0;
                    dp_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Register memory: cleared by reset, byte-masked update on write completion.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (complete_wr_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_mask_s[b]) begin
                    mem_r[word_idx_s][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_subordinate_responder.sv
// Directed bench for ahb_subordinate_responder: three instances with 0, 3 and 5 wait states
// share the address/data buses and are selected one at a time.
module tb_ahb_subordinate_responder;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [3:0]  hwstrb;
    logic [31:0] hwdata;
    logic        block_ready;
    logic [2:0]  hsel_v;
    logic [2:0]  hready_v;
    logic [2:0]  hro_v;
    logic [2:0]  hresp_v;
    logic [2:0]  hexok_v;
    logic [31:0] rd_v [3];

    int checks   = 0;
    int failures = 0;

    always #5 hclk = ~hclk;

    assign hready_v = hro_v & ~{3{block_ready}};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_subordinate_responder #(
            .ADDR_WIDTH    (32),
            .DATA_WIDTH    (32),
            .BASE_ADDR     (32'h0000_0000),
            .MEM_ADDR_BITS (8),
            .WAIT_STATES   ((g == 0) ? 0 : ((g == 1) ? 3 : 5))
        ) u_dut (
            .hclk      (hclk),
            .hreset    (hreset),
            .hselx     (hsel_v[g]),
            .haddr     (haddr),
            .htrans    (htrans),
            .hwrite    (hwrite),
            .hsize     (hsize),
            .hburst    (hburst),
            .hprot     (hprot),
            .hwstrb    (hwstrb),
            .hwdata    (hwdata),
            .hready    (hready_v[g]),
            .hreadyout (hro_v[g]),
            .hresp     (hresp_v[g]),
            .hrdata    (rd_v[g]),
            .hexokay   (hexok_v[g])
        );
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Single non-pipelined transfer; reports first-cycle hresp, wait cycles and final response.
    task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic rsp0,
                        output logic rsp, output int waits);
        hsel_v = 3'b001 << d;
        haddr  = a;
        htrans = 2'b10;
        hwrite = w;
        hsize  = sz;
        hwstrb = 4'hF;
        tick();
        hsel_v = 3'b000;
        htrans = 2'b00;
        hwdata = wd;
        rsp0   = hresp_v[d];
        waits  = 0;
        while (!hro_v[d] && waits < 64) begin
            waits++;
            tick();
        end
        rd  = rd_v[d];
        rsp = hresp_v[d];
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        rsp0;
        logic        rsp;
        int          waits;
        int          cycles;
        int          beat;

        hreset = 1'b1; hsel_v = 3'b000; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd2; hburst = 3'd0; hprot = 4'h0; hwstrb = 4'hF; hwdata = 32'h0; block_ready = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            check_value("rst_hreadyout", 32'(hro_v[d]), 32'd1);
            check_value("rst_hresp", 32'(hresp_v[d]), 32'd0);
            check_value("rst_hrdata", rd_v[d], 32'd0);
            check_value("rst_hexokay", 32'(hexok_v[d]), 32'd0);
        end
        hreset = 1'b0;
        tick();

        // Zero-wait write then back-to-back read of the same word
        hsel_v = 3'b001; haddr = 32'h10; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        tick();
        hwdata = 32'hDEAD_BEEF; hwrite = 1'b0;
        check_value("zw_wr_ready", 32'(hro_v[0]), 32'd1);
        check_value("zw_wr_resp", 32'(hresp_v[0]), 32'd0);
        tick();
        hsel_v = 3'b000; htrans = 2'b00;
        check_value("zw_rd_ready", 32'(hro_v[0]), 32'd1);
        check_value("zw_rd_data", rd_v[0], 32'hDEAD_BEEF);
        tick();

        // Byte and halfword lanes
        xfer(0, 32'h10, 1'b1, 3'd2, 32'h1122_3344, rd, rsp0, rsp, waits);
        xfer(0, 32'h13, 1'b1, 3'd0, 32'hA5A5_A5A5, rd, rsp0, rsp, waits);
        xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, rd, rsp0, rsp, waits);
        check_value("lane_byte3", rd, 32'hA522_3344);
        check_value("lane_byte_wait", 32'(waits), 32'd0);
        xfer(0, 32'h14, 1'b1, 3'd2, 32'h0, rd, rsp0, rsp, waits);
        xfer(0, 32'h16, 1'b1, 3'd1, 32'hBEEF_1234, rd, rsp0, rsp, waits);
        xfer(0, 32'h14, 1'b0, 3'd2, 32'h0, rd, rsp0, rsp, waits);
        check_value("lane_half_hi", rd, 32'hBEEF_0000);

        // Error responses
        xfer(0, 32'h0, 1'b1, 3'd2, 32'h0BAD_F00D, rd, rsp0, rsp, waits);
        xfer(0, 32'h100, 1'b0, 3'd2, 32'h0, rd, rsp0, rsp, waits);
        check_value("err_oor_resp1", 32'(rsp0), 32'd1);
        check_value("err_oor_waits", 32'(waits), 32'd1);
        check_value("err_oor_resp2", 32'(rsp), 32'd1);
        check_value("err_oor_rdata", rd, 32'd0);
        xfer(0, 32'h1, 1'b1, 3'd1, 32'hFFFF_FFFF, rd, rsp0, rsp, waits);
        check_value("err_mis_resp1", 32'(rsp0), 32'd1);
        check_value("err_mis_waits", 32'(waits), 32'd1);
        check_value("err_mis_resp2", 32'(rsp), 32'd1);
        xfer(0, 32'h0, 1'b0, 3'd2, 32'h0, rd, rsp0, rsp, waits);
        check_value("err_mem_kept", rd, 32'h0BAD_F00D);
        check_value("err_after_ok", 32'(rsp), 32'd0);
        xfer(1, 32'h0, 1'b0, 3'd3, 32'h0, rd, rsp0, rsp, waits);
        check_value("err_size_ws3_waits", 32'(waits), 32'd1);
        check_value("err_size_ws3_resp", 32'(rsp), 32'd1);

        // Wait states: single transfers and an INCR4 burst
        xfer(1, 32'h8, 1'b1, 3'd2, 32'h55AA_55AA, rd, rsp0, rsp, waits);
        check_value("ws3_wr_waits", 32'(waits), 32'd3);
        xfer(1, 32'h8, 1'b0, 3'd2, 32'h0, rd, rsp0, rsp, waits);
        check_value("ws3_rd_waits", 32'(waits), 32'd3);
        check_value("ws3_rd_data", rd, 32'h55AA_55AA);
        check_value("ws3_rd_resp", 32'(rsp), 32'd0);
        hsel_v = 3'b010; haddr = 32'h0; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; hburst = 3'b011;
        tick();
        cycles = 0;
        beat   = 1;
        while (beat <= 4 && cycles < 100) begin
            cycles++;
            if (hro_v[1]) begin
                if (beat < 4) begin
                    haddr  = 32'(beat * 4);
                    htrans = 2'b11;
                end else begin
                    htrans = 2'b00;
                    hsel_v = 3'b000;
                end
                beat++;
            end
            tick();
        end
        hburst = 3'd0;
        check_value("ws3_incr4_cycles", 32'(cycles), 32'd16);

        // IDLE while selected, unselected NONSEQ, and hready held low elsewhere
        hsel_v = 3'b010; htrans = 2'b00;
        tick();
        check_value("idle_ready", 32'(hro_v[1]), 32'd1);
        check_value("idle_resp", 32'(hresp_v[1]), 32'd0);
        hsel_v = 3'b000; htrans = 2'b10; haddr = 32'h0;
        tick();
        check_value("unsel_ready", 32'(hro_v[1]), 32'd1);
        tick();
        check_value("unsel_hold", 32'(hro_v[1]), 32'd1);
        hsel_v = 3'b010; block_ready = 1'b1;
        tick();
        check_value("nready_ready", 32'(hro_v[1]), 32'd1);
        block_ready = 1'b0; hsel_v = 3'b000; htrans = 2'b00;
        tick();
        check_value("nready_hold", 32'(hro_v[1]), 32'd1);

        // Reset during the second wait cycle of a write
        xfer(2, 32'h24, 1'b1, 3'd2, 32'h1234_5678, rd, rsp0, rsp, waits);
        check_value("ws5_wr_waits", 32'(waits), 32'd5);
        xfer(2, 32'h24, 1'b0, 3'd2, 32'h0, rd, rsp0, rsp, waits);
        check_value("ws5_rd_data", rd, 32'h1234_5678);
        hsel_v = 3'b100; haddr = 32'h20; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        tick();
        hsel_v = 3'b000; htrans = 2'b00; hwdata = 32'hCAFE_F00D;
        tick();
        check_value("rst_mid_pre_ready", 32'(hro_v[2]), 32'd0);
        #2;
        hreset = 1'b1;
        #1;
        check_value("rst_mid_ready", 32'(hro_v[2]), 32'd1);
        check_value("rst_mid_resp", 32'(hresp_v[2]), 32'd0);
        check_value("rst_mid_rdata", rd_v[2], 32'd0);
        tick();
        hreset = 1'b0;
        tick();
        xfer(2, 32'h20, 1'b0, 3'd2, 32'h0, rd, rsp0, rsp, waits);
        check_value("rst_mid_discard", rd, 32'd0);
        check_value("rst_mid_rd_waits", 32'(waits), 32'd5);
        xfer(2, 32'h24, 1'b0, 3'd2, 32'h0, rd, rsp0, rsp, waits);
        check_value("rst_mem_cleared", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
